// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite slave register bank.
// The DECERR option (AXI_LITE_SLAVE_DECERR_EN) is selected in axi_lite_slave_regs.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned REG_IDX_LSB = 2;
  localparam int unsigned IDX_W       = 10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx,
                                        input int unsigned num_regs);
    logic [IDX_W:0] limit;
    limit = num_regs[IDX_W:0];
    return {1'b0, idx} < limit;
  endfunction

endpackage

// File: rtl/axi_lite_slave_regfile.sv
// Register array with byte-strobe write port, combinational read mux and
// a hardware-driven read-only status slot in the last position.
module axi_lite_slave_regfile
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [31:0]            wr_data,
  input  logic [3:0]             wr_strb,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [31:0]            rd_data,
  input  logic [31:0]            status_in,
  output logic [NUM_REGS*32-1:0] reg_out
);

  localparam int unsigned N_RW = NUM_REGS - 1;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS - 1);

  logic [31:0] regs [N_RW];
  logic [31:0] wr_mask;

  always_comb begin
    wr_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
  end

  // Only the writable slots decode; status and out-of-range indices fall through.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_RW; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned i = 0; i < N_RW; i++) begin
        if (wr_idx == i[IDX_W-1:0]) begin
          regs[i] <= (regs[i] & ~wr_mask) | (wr_data & wr_mask);
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < N_RW; i++) begin
      if (rd_idx == i[IDX_W-1:0]) begin
        rd_data = regs[i];
      end
    end
    if (rd_idx == STATUS_IDX) begin
      rd_data = status_in;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < N_RW; i++) begin
      reg_out[32*i +: 32] = regs[i];
    end
    reg_out[32*N_RW +: 32] = status_in;
  end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register bank: independent write and read FSMs over a regfile.
// Define AXI_LITE_SLAVE_DECERR_EN to answer out-of-range accesses with DECERR.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 16
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic [31:0]                   status_in,
  output logic [NUM_REGS*32-1:0]        reg_out
);

`ifdef AXI_LITE_SLAVE_DECERR_EN
  localparam logic [1:0] OOR_RESP = RESP_DECERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  w_state_t         w_state, w_next;
  r_state_t         r_state, r_next;
  logic             active;
  logic             aw_held, w_held;
  logic [IDX_W-1:0] aw_idx;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic [1:0]       bresp;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             aw_hs, w_hs, ar_hs, commit, b_done, r_done;
  logic [IDX_W-1:0] ar_idx;
  logic [31:0]      rd_data;
  logic             unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};
  assign ar_idx      = S_AXI_ARADDR[REG_IDX_LSB +: IDX_W];

  // Readies are gated by a registered flag so they stay low through reset.
  always_comb begin
    w_next        = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    commit        = 1'b0;
    b_done        = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = active && !aw_held;
        S_AXI_WREADY  = active && !w_held;
        if (aw_held && w_held) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) begin
          b_done = 1'b1;
          w_next = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state <= W_IDLE;
      active  <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bresp   <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      active  <= 1'b1;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[REG_IDX_LSB +: IDX_W];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        bresp <= idx_in_range(aw_idx, NUM_REGS) ? RESP_OKAY : OOR_RESP;
      end
      if (b_done) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_comb begin
    r_next        = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    r_done        = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = active;
        if (S_AXI_ARVALID && active) begin
          r_next = R_DATA;
        end
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) begin
          r_done = 1'b1;
          r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // The read mux sees pre-edge contents, so a same-edge write returns old data.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state <= R_IDLE;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        rdata <= rd_data;
        rresp <= idx_in_range(ar_idx, NUM_REGS) ? RESP_OKAY : OOR_RESP;
      end
    end
  end

  assign S_AXI_BRESP = bresp;
  assign S_AXI_RDATA = rdata;
  assign S_AXI_RRESP = rresp;

  axi_lite_slave_regfile #(
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk      (S_AXI_ACLK),
    .rst      (S_AXI_ARESET),
    .wr_en    (commit),
    .wr_idx   (aw_idx),
    .wr_data  (w_data),
    .wr_strb  (w_strb),
    .rd_idx   (ar_idx),
    .rd_data  (rd_data),
    .status_in(status_in),
    .reg_out  (reg_out)
  );

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: directed cases plus random traffic
// checked against an array model of the register bank.
module tb_axi_lite_slave_regs;

  localparam int NUM_REGS = 16;
`ifdef AXI_LITE_SLAVE_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [31:0]            awaddr, wdata, araddr, status_in;
  logic [2:0]             awprot, arprot;
  logic [3:0]             wstrb;
  logic                   awvalid, awready, wvalid, wready, bvalid, bready;
  logic                   arvalid, arready, rvalid, rready;
  logic [1:0]             bresp, rresp;
  logic [31:0]            rdata;
  logic [NUM_REGS*32-1:0] reg_out;

  logic [31:0] model [1024];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_lite_slave_regs #(
    .C_S_AXI_ADDR_WIDTH(32),
    .C_S_AXI_DATA_WIDTH(32),
    .NUM_REGS          (NUM_REGS)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .status_in    (status_in),
    .reg_out      (reg_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int addr_idx(input logic [31:0] addr);
    return int'(addr[11:2]);
  endfunction

  function automatic logic [31:0] exp_read(input int idx);
    if (idx >= NUM_REGS) return 32'h0;
    if (idx == NUM_REGS - 1) return status_in;
    return model[idx];
  endfunction

  function automatic logic [1:0] exp_resp(input int idx);
    return (idx >= NUM_REGS) ? OOR_RESP : 2'b00;
  endfunction

  task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    if (idx < NUM_REGS - 1) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      check(tag, reg_out[32*i +: 32], exp_read(i));
    end
  endtask

  // Caller is at #1 after a rising edge; returns #1 after the commit edge with BVALID up.
  task automatic write_addr_data(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_fire, w_fire;
    int cyc = 0;
    while (!(aw_done && w_done)) begin
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      check("bvalid_before_aw_w", {31'b0, bvalid}, 32'h0);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done  = 1;
      cyc++;
      if (cyc > 64) begin
        check("write_handshake_timeout", 32'h1, 32'h0);
        break;
      end
    end
    awvalid = 0;
    wvalid  = 0;
    check("bvalid_at_T", {31'b0, bvalid}, 32'h0);
    @(posedge clk); #1;
    model_write(addr_idx(addr), data, strb);
    check("bvalid_at_T1", {31'b0, bvalid}, 32'h1);
    check("bresp", {30'b0, bresp}, {30'b0, exp_resp(addr_idx(addr))});
  endtask

  task automatic write_resp(input int bready_dly);
    for (int i = 0; i < bready_dly; i++) begin
      @(posedge clk); #1;
      check("bvalid_hold", {31'b0, bvalid}, 32'h1);
      check("ready_low_in_resp", {30'b0, awready, wready}, 32'h0);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    check("bvalid_cleared", {31'b0, bvalid}, 32'h0);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int bready_dly);
    write_addr_data(addr, data, strb, aw_dly, w_dly);
    write_resp(bready_dly);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rready_dly,
                          output logic [31:0] data);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    int cyc = 0;
    araddr  = addr;
    arvalid = 1;
    while (!arready) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 64) begin
        check("read_handshake_timeout", 32'h1, 32'h0);
        break;
      end
    end
    exp_d = exp_read(addr_idx(addr));
    exp_r = exp_resp(addr_idx(addr));
    @(posedge clk); #1;
    arvalid = 0;
    check("rvalid_at_T1", {31'b0, rvalid}, 32'h1);
    check("rdata", rdata, exp_d);
    check("rresp", {30'b0, rresp}, {30'b0, exp_r});
    for (int i = 0; i < rready_dly; i++) begin
      @(posedge clk); #1;
      check("rdata_stable", rdata, exp_d);
      check("arready_low_in_data", {30'b0, arready, rvalid}, 32'h1);
    end
    data   = rdata;
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    check("rvalid_cleared", {31'b0, rvalid}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, addr, data;
    int idx, op;

    rst = 1; awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awprot = 3'b010; arprot = 3'b001;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    status_in = 32'h0BADF00D;
    for (int i = 0; i < 1024; i++) model[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {29'b0, awready, wready, arready}, 32'h0);
    check("reset_valid", {30'b0, bvalid, rvalid}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_resp", {28'b0, bresp, rresp}, 32'h0);
    rst = 0;
    @(posedge clk); #1;
    check("ready_after_reset", {29'b0, awready, wready, arready}, 32'h7);
    check_all("reg_out_reset");

    // AW and W in the same cycle.
    axi_write(32'hC700_0004, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("reg1_deadbeef", reg_out[63:32], 32'hDEADBEEF);

    // W three cycles ahead of AW, partial strobes.
    axi_write(32'hC700_0008, 32'hFFFFFFFF, 4'hF, 0, 0, 1);
    axi_write(32'hC700_0008, 32'h12345678, 4'h5, 3, 0, 2);
    check("reg2_strobe", reg_out[95:64], 32'hFF34FF78);

    // Read with RREADY held low.
    axi_read(32'hC700_0004, 5, d);
    check("read_reg1", d, 32'hDEADBEEF);

    // Write commit and AR handshake on the same edge.
    awaddr = 32'hC700_000C; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    check("same_cycle_ready", {30'b0, awready, wready}, 32'h3);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    araddr = 32'hC700_000C; arvalid = 1;
    check("arready_concurrent", {31'b0, arready}, 32'h1);
    @(posedge clk); #1;
    arvalid = 0;
    check("concurrent_bvalid", {31'b0, bvalid}, 32'h1);
    check("concurrent_rvalid", {31'b0, rvalid}, 32'h1);
    check("concurrent_old_data", rdata, 32'h0);
    model_write(3, 32'hA5A5A5A5, 4'hF);
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    axi_read(32'hC700_000C, 0, d);
    check("reg3_new_data", d, 32'hA5A5A5A5);

    // Out-of-range and status slot.
    axi_write(32'hC700_0040, 32'h55555555, 4'hF, 1, 0, 0);
    check_all("reg_out_after_oor_write");
    axi_read(32'hC700_0040, 1, d);
    check("oor_read_zero", d, 32'h0);
    axi_read(32'hC700_003C, 0, d);
    check("status_read", d, 32'h0BADF00D);
    axi_write(32'hC700_003C, 32'hFFFFFFFF, 4'hF, 0, 2, 0);
    check("status_slot", reg_out[32*(NUM_REGS-1) +: 32], 32'h0BADF00D);
    check_all("reg_out_after_status_write");

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      status_in = $urandom;
      addr      = $urandom;
      idx       = $urandom_range(0, NUM_REGS + 2);
      addr[11:2] = idx[9:0];
      addr[1:0]  = 2'b00;
      op = $urandom_range(0, 1);
      if (op == 0) begin
        data = $urandom;
        axi_write(addr, data, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        check_all("reg_out_random");
      end else begin
        axi_read(addr, $urandom_range(0, 3), d);
      end
    end

    // Reset while a write response is pending.
    status_in = 32'h0;
    write_addr_data(32'hC700_0000, 32'h11223344, 4'hF, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 1024; i++) model[i] = '0;
    check("rst_bvalid", {31'b0, bvalid}, 32'h0);
    check("rst_ready", {29'b0, awready, wready, arready}, 32'h0);
    check_all("rst_reg_out");
    rst = 0;
    @(posedge clk); #1;
    check("post_rst_ready", {30'b0, awready, wready}, 32'h3);
    axi_write(32'hC700_0014, 32'hCAFEF00D, 4'hF, 0, 1, 0);
    axi_read(32'hC700_0014, 0, d);
    check("post_rst_read", d, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
